// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB register-memory completer.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned BYTES          = APB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    // Error causes, listed in decode priority order.
    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_RANGE,
        ERR_ALIGN,
        ERR_PROT,
        ERR_RSTRB
    } err_cause_e;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB4 bus bundle between the master bridge and the register-memory completer.
interface apb_slave_mem_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              psel;
    logic              penable;
    logic [AW-1:0]     paddr;
    logic              pwrite;
    logic [DW-1:0]     pwdata;
    logic [DW/8-1:0]   pstrb;
    logic [2:0]        pprot;
    logic              pready;
    logic [DW-1:0]     prdata;
    logic              pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_decode.sv
// Address decode: word index plus range/alignment/protection/read-strobe fault detection.
module apb_slave_decode #(
    parameter int unsigned             APB_ADDR_WIDTH = 32,
    parameter int unsigned             APB_DATA_WIDTH = 32,
    parameter int unsigned             MEM_DEPTH      = 64,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned             SECURE_WORDS   = 4,
    parameter int unsigned             PROT_CHECK     = 1
) (
    input  logic [APB_ADDR_WIDTH-1:0]   i_addr,
    input  logic                        i_write,
    input  logic [APB_DATA_WIDTH/8-1:0] i_strb,
    input  logic                        i_nonsec,
    output logic [$clog2(MEM_DEPTH)-1:0] o_idx,
    output logic                        o_err,
    output apb_pkg::err_cause_e         o_cause
);
    import apb_pkg::*;

    localparam int unsigned LANES = APB_DATA_WIDTH / 8;
    localparam int unsigned AL    = $clog2(LANES);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [APB_ADDR_WIDTH-1:0] SPAN       = APB_ADDR_WIDTH'(MEM_DEPTH * LANES);
    localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK = APB_ADDR_WIDTH'(LANES - 1);
    localparam logic [APB_ADDR_WIDTH-1:0] SEC_LIMIT  = APB_ADDR_WIDTH'(SECURE_WORDS);

    logic                      w_borrow;
    logic [APB_ADDR_WIDTH-1:0] w_off;
    logic [APB_ADDR_WIDTH-1:0] w_word;
    logic                      w_range_ok;
    logic                      w_misalign;
    logic                      w_prot_bad;

    // Borrow out of the subtraction flags addresses below the base.
    always_comb begin
        {w_borrow, w_off} = {1'b0, i_addr} - {1'b0, BASE_ADDR};
        w_word     = w_off >> AL;
        w_range_ok = !w_borrow && (w_off < SPAN);
        w_misalign = (i_addr & ALIGN_MASK) != '0;
        w_prot_bad = (PROT_CHECK != 0) && i_nonsec && (w_word < SEC_LIMIT);

        o_cause = ERR_NONE;
        if (!w_range_ok)                  o_cause = ERR_RANGE;
        else if (w_misalign)              o_cause = ERR_ALIGN;
        else if (w_prot_bad)              o_cause = ERR_PROT;
        else if (!i_write && i_strb != '0) o_cause = ERR_RSTRB;

        o_err = (o_cause != ERR_NONE);
        o_idx = IDX_W'(w_word);
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer terminating the bus into a word-addressed register memory with wait states.
module apb_slave_mem #(
    parameter int unsigned               APB_ADDR_WIDTH = apb_pkg::APB_ADDR_WIDTH,
    parameter int unsigned               APB_DATA_WIDTH = apb_pkg::APB_DATA_WIDTH,
    parameter int unsigned               MEM_DEPTH      = 64,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned               WAIT_CYCLES    = 2,
    parameter int unsigned               SECURE_WORDS   = 4,
    parameter int unsigned               PROT_CHECK     = 1
) (
    input  logic            clk,
    input  logic            rstn,
    apb_slave_mem_if.slave  bus
);
    import apb_pkg::*;

    localparam int unsigned LANES     = APB_DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    state_e                     r_state;
    logic [3:0]                 r_cnt;
    logic                       r_write;
    logic [APB_DATA_WIDTH-1:0]  r_wdata;
    logic [LANES-1:0]           r_strb;
    logic [IDX_W-1:0]           r_idx;
    err_cause_e                 r_cause;
    logic                       r_pready;
    logic                       r_pslverr;
    logic [APB_DATA_WIDTH-1:0]  r_prdata;
    logic [APB_DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

    logic [IDX_W-1:0]           w_idx;
    logic                       w_err;
    err_cause_e                 w_cause;
    logic                       w_setup;
    logic                       w_access;
    logic                       w_cap_err;

    apb_slave_decode #(
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .APB_DATA_WIDTH (APB_DATA_WIDTH),
        .MEM_DEPTH      (MEM_DEPTH),
        .BASE_ADDR      (BASE_ADDR),
        .SECURE_WORDS   (SECURE_WORDS),
        .PROT_CHECK     (PROT_CHECK)
    ) u_decode (
        .i_addr   (bus.paddr),
        .i_write  (bus.pwrite),
        .i_strb   (bus.pstrb),
        .i_nonsec (bus.pprot[1]),
        .o_idx    (w_idx),
        .o_err    (w_err),
        .o_cause  (w_cause)
    );

    assign w_setup   = bus.psel && !bus.penable;
    assign w_access  = bus.psel && bus.penable;
    assign w_cap_err = (r_cause != ERR_NONE);

    assign bus.pready  = r_pready;
    assign bus.pslverr = r_pslverr;
    assign bus.prdata  = r_prdata;

    // Transfer FSM; the memory write commits only on a completed, fault-free DONE cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_idx     <= '0;
            r_cause   <= ERR_NONE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_write <= bus.pwrite;
                        r_wdata <= bus.pwdata;
                        r_strb  <= bus.pstrb;
                        r_idx   <= w_idx;
                        r_cause <= w_cause;
                        if (WAIT_CYCLES == 0) begin
                            r_state   <= DONE;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= (w_err || bus.pwrite) ? '0 : r_mem[w_idx];
                        end else begin
                            r_cnt   <= WAIT_LOAD;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!w_access) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt     <= '0;
                        r_state   <= DONE;
                        r_pready  <= 1'b1;
                        r_pslverr <= w_cap_err;
                        r_prdata  <= (w_cap_err || r_write) ? '0 : r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                    if (w_access && r_write && !w_cap_err) begin
                        for (int b = 0; b < LANES; b++) begin
                            if (r_strb[b]) r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
